// File: rtl/led_status_pkg.sv
// Shared state encodings for the LED/status controller and its activity channels.
package led_status_pkg;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_ON   = 2'd1,
    CH_OFF  = 2'd2
  } ch_state_t;

  typedef enum logic {
    PHY_HOLD = 1'b0,
    PHY_RUN  = 1'b1
  } phy_state_t;

endpackage

// File: rtl/led_status_if.sv
// Activity bundle: trigger strobes in, stretched LED indications out.
interface led_status_if #(
  parameter int W = 1
);
  logic [W-1:0] trigger;
  logic [W-1:0] act_led;

  modport master (output trigger, input act_led);
  modport slave  (input trigger, output act_led);
endinterface

// File: rtl/act_stretch.sv
// One activity-LED channel: stretches a trigger strobe to 2^STRETCH_W cycles,
// optionally followed by an equal dark phase so sustained traffic blinks.
module act_stretch
  import led_status_pkg::*;
#(
  parameter int STRETCH_W = 22,
  parameter bit BLINK     = 1'b1
)(
  input logic          clk,
  input logic          rstn,
  led_status_if.slave  bus
);

  localparam logic [STRETCH_W-1:0] ONE = {{(STRETCH_W-1){1'b0}}, 1'b1};

  ch_state_t            state_reg, state_next;
  logic [STRETCH_W-1:0] cnt_reg, cnt_next;
  logic                 pend_reg, pend_next;
  logic                 trig;

  assign trig        = bus.trigger[0];
  assign bus.act_led = (state_reg == CH_ON);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= CH_IDLE;
      cnt_reg   <= '0;
      pend_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pend_reg  <= pend_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pend_next  = pend_reg;
    case (state_reg)
      CH_IDLE: begin
        if (trig) begin
          state_next = CH_ON;
          cnt_next   = '1;
        end
      end
      CH_ON: begin
        if (!BLINK && trig) begin
          cnt_next = '1;
        end else if (cnt_reg == '0) begin
          if (BLINK) begin
            state_next = CH_OFF;
            cnt_next   = '1;
          end else begin
            state_next = CH_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - ONE;
        end
      end
      CH_OFF: begin
        if (trig) begin
          pend_next = 1'b1;
        end
        // A strobe in the last dark cycle still counts as pending traffic.
        if (cnt_reg == '0) begin
          if (pend_reg || trig) begin
            state_next = CH_ON;
            cnt_next   = '1;
            pend_next  = 1'b0;
          end else begin
            state_next = CH_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - ONE;
        end
      end
      default: begin
        state_next = CH_IDLE;
        cnt_next   = '0;
        pend_next  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/led_status_ctl.sv
// Board status LEDs: per-channel activity stretchers, heartbeat/user LED and
// a PHY reset sequencer gated on a synchronised PLL lock.
module led_status_ctl
  import led_status_pkg::*;
#(
  parameter int N_ACT      = 2,
  parameter int STRETCH_W  = 22,
  parameter int BLINK      = 1,
  parameter int HB_W       = 27,
  parameter int PHY_HOLD_W = 22
)(
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_ACT-1:0] trigger,
  input  logic             clk_locked,
  input  logic             phy_reset_req,
  input  logic             user_mode,
  input  logic             user_led,
  output logic [N_ACT-1:0] act_led,
  output logic             hb_led,
  output logic             phy_rstn,
  output logic             phy_ready
);

  localparam logic [HB_W-1:0]       HB_ONE  = {{(HB_W-1){1'b0}}, 1'b1};
  localparam logic [PHY_HOLD_W-1:0] PHY_ONE = {{(PHY_HOLD_W-1){1'b0}}, 1'b1};

  genvar gi;
  generate
    for (gi = 0; gi < N_ACT; gi++) begin : g_ch
      led_status_if #(.W(1)) ch_bus ();
      assign ch_bus.trigger = trigger[gi];
      assign act_led[gi]    = ch_bus.act_led[0];
      act_stretch #(
        .STRETCH_W (STRETCH_W),
        .BLINK     (BLINK != 0)
      ) u_ch (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ch_bus.slave)
      );
    end
  endgenerate

  logic [HB_W-1:0] hb_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) hb_reg <= '0;
    else       hb_reg <= hb_reg + HB_ONE;
  end

  assign hb_led = user_mode ? user_led : hb_reg[HB_W-1];

  // clk_locked comes straight from the PLL, unrelated to clk.
  logic [1:0] sync_reg;
  logic       locked_s;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_reg <= 2'b00;
    else       sync_reg <= {sync_reg[0], clk_locked};
  end

  assign locked_s = sync_reg[1];

  phy_state_t            phy_state_reg, phy_state_next;
  logic [PHY_HOLD_W-1:0] phy_cnt_reg, phy_cnt_next;
  logic                  phy_rstn_reg, phy_rstn_next;
  logic                  phy_ready_reg, phy_ready_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phy_state_reg <= PHY_HOLD;
      phy_cnt_reg   <= '0;
      phy_rstn_reg  <= 1'b0;
      phy_ready_reg <= 1'b0;
    end else begin
      phy_state_reg <= phy_state_next;
      phy_cnt_reg   <= phy_cnt_next;
      phy_rstn_reg  <= phy_rstn_next;
      phy_ready_reg <= phy_ready_next;
    end
  end

  always_comb begin
    phy_state_next = phy_state_reg;
    phy_cnt_next   = phy_cnt_reg;
    phy_ready_next = 1'b0;
    case (phy_state_reg)
      PHY_HOLD: begin
        if (!locked_s || phy_reset_req) begin
          phy_cnt_next = '0;
        end else if (&phy_cnt_reg) begin
          phy_state_next = PHY_RUN;
          phy_cnt_next   = '0;
          phy_ready_next = 1'b1;
        end else begin
          phy_cnt_next = phy_cnt_reg + PHY_ONE;
        end
      end
      PHY_RUN: begin
        if (!locked_s || phy_reset_req) begin
          phy_state_next = PHY_HOLD;
          phy_cnt_next   = '0;
        end
      end
      default: begin
        phy_state_next = PHY_HOLD;
        phy_cnt_next   = '0;
      end
    endcase
    // Registered from the next state so the pin is a clean flop output tracking RUN.
    phy_rstn_next = (phy_state_next == PHY_RUN);
  end

  assign phy_rstn  = phy_rstn_reg;
  assign phy_ready = phy_ready_reg;

endmodule

// File: tb/tb_led_status_ctl.sv
// Bench for led_status_ctl: a blink-mode and a retrigger-mode instance, timed expectations via a scoreboard queue.
module tb_led_status_ctl;

  logic clk = 1'b0;
  logic rstn;
  logic clk_locked, phy_reset_req, user_mode, user_led;
  logic hb_b, hb_r, phy_rstn_b, phy_rstn_r, phy_ready_b, phy_ready_r;

  led_status_if #(.W(2)) bus_b ();
  led_status_if #(.W(2)) bus_r ();

  always #5 clk = ~clk;

  led_status_ctl #(.N_ACT(2), .STRETCH_W(3), .BLINK(1), .HB_W(4), .PHY_HOLD_W(4)) dut_b (
    .clk(clk), .rstn(rstn), .trigger(bus_b.trigger), .clk_locked(clk_locked),
    .phy_reset_req(phy_reset_req), .user_mode(user_mode), .user_led(user_led),
    .act_led(bus_b.act_led), .hb_led(hb_b), .phy_rstn(phy_rstn_b), .phy_ready(phy_ready_b)
  );

  led_status_ctl #(.N_ACT(2), .STRETCH_W(3), .BLINK(0), .HB_W(4), .PHY_HOLD_W(4)) dut_r (
    .clk(clk), .rstn(rstn), .trigger(bus_r.trigger), .clk_locked(clk_locked),
    .phy_reset_req(phy_reset_req), .user_mode(user_mode), .user_led(user_led),
    .act_led(bus_r.act_led), .hb_led(hb_r), .phy_rstn(phy_rstn_r), .phy_ready(phy_ready_r)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs_of(input int sel);
    case (sel)
      0:       return {31'b0, bus_b.act_led[0]};
      1:       return {31'b0, bus_b.act_led[1]};
      2:       return {31'b0, bus_r.act_led[0]};
      3:       return {31'b0, phy_rstn_b};
      4:       return {31'b0, phy_ready_b};
      5:       return {31'b0, hb_b};
      default: return 32'hdead;
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sel, input logic e);
    sb_q.push_back('{tag, sel, {31'b0, e}});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance one cycle, then settle every expectation queued for it.
  task automatic step_check();
    sb_t e;
    tick();
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, obs_of(e.sel), e.exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic v;
    bit  seen;

    rstn = 1'b0; clk_locked = 1'b0; phy_reset_req = 1'b0;
    user_mode = 1'b0; user_led = 1'b0;
    bus_b.trigger = 2'b00; bus_r.trigger = 2'b00;

    repeat (3) tick();
    check_val("rst_act_b", {30'b0, bus_b.act_led}, 32'd0);
    check_val("rst_act_r", {30'b0, bus_r.act_led}, 32'd0);
    check_val("rst_phy_rstn", {31'b0, phy_rstn_b}, 32'd0);
    check_val("rst_phy_ready", {31'b0, phy_ready_b}, 32'd0);
    check_val("rst_hb", {31'b0, hb_b}, 32'd0);
    rstn = 1'b1;

    // PHY bring-up: lock seen at cycle 0, release at cycle 18.
    for (int c = 0; c <= 24; c++) begin
      clk_locked = 1'b1;
      n = c + 1;
      push_exp("bringup_rstn", 3, n >= 18);
      push_exp("bringup_ready", 4, n == 18);
      step_check();
    end
    $display("bringup done: phy_rstn=%0d", phy_rstn_b);

    // PHY recovery: one-cycle lock drop, reset request during hold, request during run.
    for (int c = 0; c <= 50; c++) begin
      clk_locked    = (c != 0);
      phy_reset_req = (c == 8) || (c == 30);
      n = c + 1;
      push_exp("recov_rstn", 3, (n <= 2) || (n >= 25 && n <= 30) || (n >= 47));
      push_exp("recov_ready", 4, (n == 25) || (n == 47));
      step_check();
    end
    phy_reset_req = 1'b0;
    $display("recovery done: phy_rstn=%0d", phy_rstn_b);

    // Single pulse at 10 (ON 11..18, OFF 19..26), second pulse on return to IDLE at 27.
    for (int c = 0; c <= 40; c++) begin
      bus_b.trigger = ((c == 10) || (c == 27)) ? 2'b01 : 2'b00;
      n = c + 1;
      push_exp("pulse_act0", 0, (n >= 11 && n <= 18) || (n >= 28 && n <= 35));
      push_exp("pulse_act1", 1, 1'b0);
      step_check();
    end
    bus_b.trigger = 2'b00;
    repeat (10) tick();
    $display("single pulse done");

    // Held trigger gives an 8-on/8-off blink; the OFF phase picks up pending traffic.
    for (int c = 0; c <= 40; c++) begin
      bus_b.trigger = (c <= 39) ? 2'b01 : 2'b00;
      n = c + 1;
      push_exp("held_act0", 0, ((n - 1) / 8) % 2 == 0);
      push_exp("held_act1", 1, 1'b0);
      step_check();
    end
    bus_b.trigger = 2'b00;
    repeat (12) tick();
    $display("held trigger done");

    // Both channels triggered together.
    for (int c = 0; c <= 10; c++) begin
      bus_b.trigger = (c == 0) ? 2'b11 : 2'b00;
      n = c + 1;
      push_exp("both_act0", 0, n >= 1 && n <= 8);
      push_exp("both_act1", 1, n >= 1 && n <= 8);
      step_check();
    end
    repeat (12) tick();
    $display("simultaneous done");

    // Retriggerable instance: pulses at 10 and 15 keep the LED on 11..23.
    for (int c = 0; c <= 30; c++) begin
      bus_r.trigger = ((c == 10) || (c == 15)) ? 2'b01 : 2'b00;
      n = c + 1;
      push_exp("retrig_act0", 2, n >= 11 && n <= 23);
      step_check();
    end
    bus_r.trigger = 2'b00;
    $display("retrigger done");

    // Heartbeat: find an edge, then expect a toggle every 8 cycles.
    seen = 1'b0;
    v = hb_b;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (hb_b !== v) seen = 1'b1;
    end
    check_val("hb_edge_seen", {31'b0, seen}, 32'd1);
    v = hb_b;
    for (int k = 1; k <= 24; k++) begin
      push_exp("hb_toggle", 5, v ^ ((k / 8) % 2 == 1));
      step_check();
    end
    $display("heartbeat done");

    // User LED override is combinational.
    user_mode = 1'b1; user_led = 1'b1; #1;
    check_val("user_led_1", {31'b0, hb_b}, 32'd1);
    user_led = 1'b0; #1;
    check_val("user_led_0", {31'b0, hb_b}, 32'd0);
    user_mode = 1'b0;

    // Asynchronous reset while a channel is ON and the PHY is in RUN.
    bus_b.trigger = 2'b01;
    tick();
    bus_b.trigger = 2'b00;
    tick();
    check_val("pre_rst_act0", {31'b0, bus_b.act_led[0]}, 32'd1);
    check_val("pre_rst_phy_rstn", {31'b0, phy_rstn_b}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    check_val("async_act0", {31'b0, bus_b.act_led[0]}, 32'd0);
    check_val("async_phy_rstn", {31'b0, phy_rstn_b}, 32'd0);
    check_val("async_phy_ready", {31'b0, phy_ready_b}, 32'd0);
    repeat (3) tick();
    check_val("hold_act0", {31'b0, bus_b.act_led[0]}, 32'd0);
    rstn = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      push_exp("post_rst_act0", 0, 1'b0);
      push_exp("post_rst_rstn", 3, 1'b0);
      step_check();
    end
    $display("async reset done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_status_ctl.md
LED_STATUS_CTL -- requirements
Module: led_status_ctl

Interface
REQ-001 SHALL have parameter N_ACT, default 2, the number of activity-LED channels.
REQ-002 SHALL have parameter STRETCH_W, default 22; each stretch phase lasts 2^STRETCH_W cycles.
REQ-003 SHALL have parameter BLINK, default 1; 1 selects blink mode, 0 selects retriggerable mode.
REQ-004 SHALL have parameter HB_W, default 27, the heartbeat counter width.
REQ-005 SHALL have parameter PHY_HOLD_W, default 22; the PHY reset hold lasts 2^PHY_HOLD_W cycles.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port trigger, input, N_ACT bits: per-channel activity strobes, synchronous to clk.
REQ-009 SHALL have port clk_locked, input, 1 bit: PLL lock, asynchronous to clk.
REQ-010 SHALL have port phy_reset_req, input, 1 bit: single-cycle request to re-run the PHY reset.
REQ-011 SHALL have port user_mode, input, 1 bit: when 1, hb_led is driven from user_led.
REQ-012 SHALL have port user_led, input, 1 bit: software-driven LED value.
REQ-013 SHALL have port act_led, output, N_ACT bits: stretched activity indicators.
REQ-014 SHALL have port hb_led, output, 1 bit: heartbeat LED or user LED.
REQ-015 SHALL have port phy_rstn, output, 1 bit: PHY reset, active-low.
REQ-016 SHALL have port phy_ready, output, 1 bit: one-cycle pulse when phy_rstn is released.

Function
REQ-017 SHALL run each channel as an FSM with states IDLE, ON and OFF, plus a STRETCH_W-bit down-counter.
REQ-018 In IDLE with trigger[i]=1, a channel SHALL load the counter with 2^STRETCH_W-1, enter ON, and assert act_led[i] on the next cycle.
REQ-019 act_led[i] SHALL be 1 exactly while the channel is in ON, i.e. for 2^STRETCH_W cycles per activation.
REQ-020 In blink mode (BLINK=1), when the counter reaches 0 in ON, the channel SHALL reload the counter and enter OFF for 2^STRETCH_W cycles.
REQ-021 In blink mode, a trigger during ON SHALL be ignored, and a trigger during OFF SHALL set a pending flag.
REQ-022 At the end of OFF, the channel SHALL enter ON if the pending flag is set (clearing it), else IDLE; continuous traffic therefore gives a 50% blink.
REQ-023 In retriggerable mode (BLINK=0), a trigger during ON SHALL reload the counter, OFF SHALL never be entered, and ON SHALL go straight to IDLE at counter 0.
REQ-024 Channels SHALL operate independently; simultaneous triggers on all channels SHALL be serviced in the same cycle.
REQ-025 The heartbeat counter SHALL be a free-running HB_W-bit counter that wraps from all-ones to 0.
REQ-026 hb_led SHALL equal user_led when user_mode=1, else the heartbeat counter MSB; this selection is combinational.
REQ-027 clk_locked SHALL pass through a 2-flop synchroniser to give locked_s.
REQ-028 The PHY FSM SHALL have states HOLD and RUN, with a PHY_HOLD_W-bit up-counter.
REQ-029 In HOLD, the counter SHALL increment only while locked_s=1, and SHALL clear whenever locked_s=0.
REQ-030 In HOLD, when the counter reaches all-ones with locked_s=1, the FSM SHALL enter RUN; phy_rstn SHALL rise and phy_ready SHALL pulse for one cycle.
REQ-031 In RUN, locked_s=0 or phy_reset_req=1 SHALL return the FSM to HOLD with the counter cleared, and phy_rstn SHALL go low on the next cycle.
REQ-032 phy_reset_req asserted in HOLD SHALL clear the counter, restarting the hold.
REQ-033 phy_rstn SHALL be registered, SHALL equal 1 only in RUN, and SHALL be glitch-free.

Reset
REQ-034 While rstn=0, the block SHALL hold: all channels in IDLE, counters and pending flags at 0, act_led=0.
REQ-035 While rstn=0, the block SHALL also hold: heartbeat=0, synchroniser flops=0, PHY FSM in HOLD, phy_rstn=0, phy_ready=0.
REQ-036 Assertion of rstn mid-operation SHALL force the reset values immediately, regardless of clk.
REQ-037 Deassertion of rstn SHALL take effect on the clk edge, with no pending state retained.

Structure
REQ-038 Package led_status_pkg SHALL hold the channel state encodings (IDLE/ON/OFF) and the PHY state encodings (HOLD/RUN).
REQ-039 Each activity channel SHALL be an instance of sub-module act_stretch, parameterised by STRETCH_W and BLINK and generated N_ACT times.
REQ-040 The heartbeat, synchroniser and PHY FSM SHALL be implemented inline in led_status_ctl.

Verification (STRETCH_W=3, HB_W=4, PHY_HOLD_W=4, N_ACT=2)
REQ-041 Blink mode: trigger[0] pulse at cycle 10 -> act_led[0]=1 for cycles 11..18, 0 from 19, IDLE at 27; act_led[1]=0 throughout.
REQ-042 Blink mode: trigger[0] held high -> act_led[0] toggles every 8 cycles; pending set in OFF causes ON at the end of OFF.
REQ-043 BLINK=0: triggers at cycles 10 and 15 -> act_led[0]=1 for cycles 11..23, then 0.
REQ-044 PHY bring-up: clk_locked rises at cycle 0 -> phy_rstn rises at cycle 18 with phy_ready=1 for that cycle only.
REQ-045 PHY recovery: in RUN, drop clk_locked for 1 cycle -> phy_rstn=0 within 3 cycles; then phy_reset_req pulse during HOLD -> hold restarts, full 16-count required.
REQ-046 Reset mid-operation: rstn low during ON and RUN -> act_led=0 and phy_rstn=0 immediately; user_mode=1 with user_led=1 -> hb_led=1; user_mode=0 -> hb_led toggles every 8 cycles.
